// File: rtl/clock_div_multi.sv
// clock_div_multi
//   Multi-channel programmable clock-enable / divided-clock generator.
//   Each channel counts 0..R-1 and drives clk_div high for the first H
//   counts of every period, plus a one-cycle tick on count 0. Ratio and
//   high (and phase, when enabled) are written into a shadow and moved to
//   the active registers only at a period boundary, while the channel is
//   stopped, or on sync_all. A period in progress is therefore never cut
//   short or glitched.
//
// Optional feature: define CLOCK_DIV_PHASE_EN to add cfg_phase and a
//   per-channel start offset used on channel start and on sync_all.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   en           in   [NUM_CH] per-channel run enable
//   sync_all     in   restart every running channel on the same edge
//   cfg_we       in   configuration write strobe
//   cfg_ch       in   [CH_W] target channel (>= NUM_CH is ignored)
//   cfg_ratio    in   [CNT_W] period in clock cycles
//   cfg_high     in   [CNT_W] high cycles per period
//   cfg_phase    in   [CNT_W] start offset (CLOCK_DIV_PHASE_EN only)
//   cfg_pending  out  [NUM_CH] shadow written but not yet applied
//   clk_div      out  [NUM_CH] divided clock, duty high/ratio
//   tick         out  [NUM_CH] pulse on the first cycle of each period
module clock_div_multi #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int DEF_RATIO = 2,
  parameter int DEF_HIGH  = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_all,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_ratio,
  input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLOCK_DIV_PHASE_EN
  input  logic [CNT_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] tick
);

  // A ratio below 2 cannot toggle; force the minimum.
  function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] ratio);
    logic [CNT_W-1:0] result;
    if (ratio < CNT_W'(2)) result = CNT_W'(2);
    else                   result = ratio;
    return result;
  endfunction

  // High must lie in 1..ratio-1 so the output always has both levels.
  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] high,
                                                  input logic [CNT_W-1:0] ratio);
    logic [CNT_W-1:0] result;
    if (high == CNT_W'(0))  result = CNT_W'(1);
    else if (high >= ratio) result = ratio - CNT_W'(1);
    else                    result = high;
    return result;
  endfunction

`ifdef CLOCK_DIV_PHASE_EN
  // Phase is an initial count, so it must stay inside 0..ratio-1.
  function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] phase,
                                                   input logic [CNT_W-1:0] ratio);
    logic [CNT_W-1:0] result;
    if (phase >= ratio) result = ratio - CNT_W'(1);
    else                result = phase;
    return result;
  endfunction
`endif

  int               ch_idx_s;
  logic             ch_valid_s;
  logic [CNT_W-1:0] wr_ratio_s;
  logic [CNT_W-1:0] wr_high_s;

  // Decode the write target and clamp the incoming fields once for all channels.
  always_comb begin
    ch_idx_s   = int'(cfg_ch);
    ch_valid_s = (ch_idx_s < NUM_CH);
    wr_ratio_s = clamp_ratio(cfg_ratio);
    wr_high_s  = clamp_high(cfg_high, wr_ratio_s);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             run_r, pend_r;
    logic [CNT_W-1:0] cnt_r, ratio_r, high_r, sratio_r, shigh_r;
    logic             run_s, pend_s, wr_s, wrap_s, apply_s;
    logic [CNT_W-1:0] cnt_s, ratio_s, high_s, sratio_s, shigh_s, start_s;
`ifdef CLOCK_DIV_PHASE_EN
    logic [CNT_W-1:0] phase_r, sphase_r, phase_s, sphase_s;
`endif

    // Next-state: count, boundary apply of the shadow, shadow writes.
    always_comb begin
      wr_s   = cfg_we && ch_valid_s && (ch_idx_s == g);
      wrap_s = (cnt_r == ratio_r - CNT_W'(1));
      // A stopped channel applies at once; a running one only at a boundary or sync.
      if (!run_r)                apply_s = pend_r;
      else if (sync_all || wrap_s) apply_s = pend_r;
      else                       apply_s = 1'b0;

      if (apply_s) begin
        ratio_s = sratio_r;
        high_s  = shigh_r;
      end else begin
        ratio_s = ratio_r;
        high_s  = high_r;
      end
`ifdef CLOCK_DIV_PHASE_EN
      if (apply_s) phase_s = clamp_phase(sphase_r, sratio_r);
      else         phase_s = phase_r;
      start_s = phase_s;
`else
      start_s = {CNT_W{1'b0}};
`endif

      run_s = en[g];
      if (!run_r) begin
        if (en[g]) cnt_s = start_s;
        else       cnt_s = {CNT_W{1'b0}};
      end else if (sync_all) begin
        cnt_s = start_s;
      end else if (wrap_s) begin
        cnt_s = {CNT_W{1'b0}};
      end else begin
        cnt_s = cnt_r + CNT_W'(1);
      end

      // A write on the apply edge lands in the shadow and keeps pending set.
      if (wr_s) begin
        sratio_s = wr_ratio_s;
        shigh_s  = wr_high_s;
        pend_s   = 1'b1;
      end else if (apply_s) begin
        sratio_s = sratio_r;
        shigh_s  = shigh_r;
        pend_s   = 1'b0;
      end else begin
        sratio_s = sratio_r;
        shigh_s  = shigh_r;
        pend_s   = pend_r;
      end
`ifdef CLOCK_DIV_PHASE_EN
      if (wr_s) sphase_s = cfg_phase;
      else      sphase_s = sphase_r;
`endif
    end

    // Channel state registers.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        run_r    <= 1'b0;
        pend_r   <= 1'b0;
        cnt_r    <= {CNT_W{1'b0}};
        ratio_r  <= CNT_W'(DEF_RATIO);
        high_r   <= CNT_W'(DEF_HIGH);
        sratio_r <= CNT_W'(DEF_RATIO);
        shigh_r  <= CNT_W'(DEF_HIGH);
`ifdef CLOCK_DIV_PHASE_EN
        phase_r  <= {CNT_W{1'b0}};
        sphase_r <= {CNT_W{1'b0}};
`endif
      end else begin
        run_r    <= run_s;
        pend_r   <= pend_s;
        cnt_r    <= cnt_s;
        ratio_r  <= ratio_s;
        high_r   <= high_s;
        sratio_r <= sratio_s;
        shigh_r  <= shigh_s;
`ifdef CLOCK_DIV_PHASE_EN
        phase_r  <= phase_s;
        sphase_r <= sphase_s;
`endif
      end
    end

    // Outputs decode registers only, so they drop as soon as reset asserts.
    assign clk_div[g]     = run_r & (cnt_r < high_r);
    assign tick[g]        = run_r & (cnt_r == {CNT_W{1'b0}});
    assign cfg_pending[g] = pend_r;
  end

endmodule
